// File: rtl/mips_arb_pkg.sv
// Shared types and constants for the mips instruction/data memory arbiter.
package mips_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mips_arb_priority.sv
// Winner selection between fetch and data ports, with a saturating counter
// that forces a fetch grant after STARVE_MAX consecutive data grants.
module mips_arb_priority
    import mips_arb_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req,
    input  logic             d_req,
    input  logic             grant,
    output owner_t           winner,
    output logic [CNT_W-1:0] starve_cnt
);

    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic [CNT_W-1:0] r_starveCnt;
    logic             w_fetchWins;

    assign w_fetchWins = i_req && (!d_req || (r_starveCnt == STARVE_LIMIT));
    assign winner      = w_fetchWins ? OWN_I : OWN_D;
    assign starve_cnt  = r_starveCnt;

    // Only data grants that leave a fetch waiting count toward starvation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starveCnt <= '0;
        end else if (grant) begin
            if (w_fetchWins) begin
                r_starveCnt <= '0;
            end else if (i_req && (r_starveCnt != STARVE_LIMIT)) begin
                r_starveCnt <= r_starveCnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port synchronous memory between the mips fetch and
// load/store ports, one access at a time with a fixed read latency.
module mips_mem_arbiter
    import mips_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            r_state;
    state_t            w_stateNext;
    owner_t            r_owner;
    owner_t            w_winner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_iRdata;
    logic [DATA_W-1:0] r_dRdata;
    logic              w_grant;
    logic [CNT_W-1:0]  w_starveCnt;

    assign w_grant = (r_state == IDLE) && (i_req || d_req);

    mips_arb_priority #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .d_req      (d_req),
        .grant      (w_grant),
        .winner     (w_winner),
        .starve_cnt (w_starveCnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        m_en        = 1'b0;
        m_we        = 1'b0;
        i_ack       = 1'b0;
        d_ack       = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_grant) begin
                    w_stateNext = ISSUE;
                end
            end
            ISSUE: begin
                m_en        = 1'b1;
                m_we        = r_we;
                w_stateNext = WAIT;
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_stateNext = RESP;
                end
            end
            RESP: begin
                i_ack       = (r_owner == OWN_I);
                d_ack       = (r_owner == OWN_D);
                w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Request fields are latched at grant so requesters may change them afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner  <= OWN_I;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_iRdata <= '0;
            r_dRdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_winner;
                        if (w_winner == OWN_D) begin
                            r_we    <= d_we;
                            r_addr  <= d_addr;
                            r_wdata <= d_wdata;
                        end else begin
                            r_we    <= 1'b0;
                            r_addr  <= i_addr;
                            r_wdata <= '0;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt <= LAT_LOAD;
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        if (!r_we) begin
                            if (r_owner == OWN_I) begin
                                r_iRdata <= m_rdata;
                            end else begin
                                r_dRdata <= m_rdata;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign i_rdata = r_iRdata;
    assign d_rdata = r_dRdata;

endmodule
